// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB first,
// with a start/busy/done handshake. {carry_out, sum} = operand_a + operand_b.
module serial_adder #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic             bit_sum;
    logic             bit_carry;
    logic             last_bit;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic parity3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    always_comb begin
        bit_sum   = parity3(sh_a[0], sh_b[0], carry);
        bit_carry = majority(sh_a[0], sh_b[0], carry);
        acc_next  = {bit_sum, acc[WIDTH-1:1]};
        last_bit  = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers only move on the edge that enters DONE, so sum and
    // carry_out hold the previous answer for the whole SHIFT phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a      <= '0;
            sh_b      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= operand_a;
                        sh_b  <= operand_b;
                        acc   <= '0;
                        carry <= 1'b0;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
                    acc   <= acc_next;
                    carry <= bit_carry;
                    count <= count + CW'(1);
                    if (last_bit) begin
                        sum       <= acc_next;
                        carry_out <= bit_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
